mpmc10_strip_engine: RTL and testbench
======================================

Name: mpmc10_strip_engine

Overview:
- Datapath and command engine slaved to the mpmc10 controller state machine.
- Consumes the controller's `state` and drives the DDR (MIG) app interface: command, address and write-data.
- Produces `req_strip_cnt` / `resp_strip_cnt` back to the controller.
- Assembles multi-strip read responses into one line and presents it with a valid pulse.

Parameters:
- DATA_W, 128, width of one strip / app data bus
- ADDR_W, 29, app address width
- MAX_STRIPS, 4, line buffer depth in strips; line width = DATA_W*MAX_STRIPS
- STRIP_INC, 16, address increment per strip (bytes)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- state  in  mpmc10_state_t  controller state
- num_strips  in  6  index of last strip (strip count minus 1)
- req_adr  in  ADDR_W  line base address, sampled in PRESET3
- req_dat  in  DATA_W  write data, sampled in PRESET3
- req_sel  in  DATA_W/8  byte enables, sampled in PRESET3
- app_rdy  in  1  MIG command accept
- app_rd_data_valid  in  1  MIG read beat valid
- app_rd_data  in  DATA_W  MIG read data
- app_en  out  1  command strobe
- app_cmd  out  3  CMD_READ / CMD_WRITE
- app_addr  out  ADDR_W  command address
- app_wdf_wren  out  1  write-data strobe
- app_wdf_end  out  1  last write beat
- app_wdf_data  out  DATA_W  write data
- app_wdf_mask  out  DATA_W/8  write mask, active-high = byte NOT written (~sel)
- req_strip_cnt  out  6  accepted read commands, saturating at num_strips
- resp_strip_cnt  out  6  received read beats, saturating at num_strips
- line_dat  out  DATA_W*MAX_STRIPS  assembled read line
- line_valid  out  1  one-cycle pulse, line_dat complete

Behaviour:
- Interface: one clock (`clk`); reset (`rst`) is synchronous and active-high.
- Reset values: all outputs 0; line buffer, address and count registers 0.
- Effective last index: eff = min(num_strips, MAX_STRIPS-1), evaluated every cycle.
- PRESET3:
  - Latch app_addr <= req_adr.
  - Latch write data <= req_dat.
  - Latch app_wdf_mask <= ~req_sel.
- READ_DATA0:
  - req_strip_cnt <= 0, resp_strip_cnt <= 0.
  - line_dat unchanged.
- READ_DATA1:
  - app_en = 1 and app_cmd = CMD_READ, combinational from state, for every cycle in this state.
  - On app_rdy with req_strip_cnt != eff: req_strip_cnt++ and app_addr += STRIP_INC (registered, visible next cycle).
  - On app_rdy with req_strip_cnt == eff: hold count and address. The controller exits this same cycle, so exactly eff+1 commands are accepted.
- READ_DATA1/READ_DATA2, response capture:
  - On app_rd_data_valid, write app_rd_data into slot resp_strip_cnt of the line buffer.
  - Then resp_strip_cnt++ if != eff, else hold.
  - Beats may arrive while still in READ_DATA1 and must be captured there too.
  - Beats arriving in any other state are dropped.
- line_valid: pulses in the cycle after the final beat, i.e. app_rd_data_valid && resp_strip_cnt==eff, registered. Slots above eff keep stale data.
- WRITE_DATA0: no outputs asserted. The controller is waiting on wdf_rdy.
- WRITE_DATA1:
  - app_wdf_wren = 1, app_wdf_end = 1, for one cycle (single-beat write).
  - app_wdf_data = latched data.
- WRITE_DATA2: app_en = 1, app_cmd = CMD_WRITE until app_rdy. The address is unchanged.
- All other states (IDLE, PRESET1/2, WRITE_DATA3, WAIT_NACK, default): app_en, app_wdf_wren, app_wdf_end = 0.
- Controller time-out (state forced to IDLE mid-read): app_en drops immediately. Counts and buffer hold until the next READ_DATA0. No line_valid is generated unless the final beat was already captured.
- Simultaneous command accept and read beat in the same cycle: both counters update independently.
- Counter arithmetic is 6-bit unsigned. Neither counter ever exceeds eff.
- Reset mid-operation: all state is cleared next cycle; line_valid = 0.

Decomposition:
- mpmc10_pkg:
  - mpmc10_state_t (existing)
  - CMD_READ = 3'b001, CMD_WRITE = 3'b000
  - default STRIP_INC
- Sub-module mpmc10_strip_buffer holds the line assembly:
  - MAX_STRIPS x DATA_W register file.
  - Ports: clk, rst, we, idx, din, line out.
- mpmc10_strip_engine holds the counters, address and app-signal decode.

Test Plan:
- Read, num_strips=3, req_adr=0x100, app_rdy=1:
  - app_addr goes 0x100, 0x110, 0x120, 0x130 across READ_DATA1.
  - req_strip_cnt ends at 3.
  - Beats A,B,C,D produce line_dat={D,C,B,A} with one line_valid pulse.
- Read, num_strips=1, app_rdy toggled 1,0,0,1:
  - Exactly 2 commands accepted.
  - app_addr advances only on accept cycles.
- Early response, num_strips=1:
  - First beat arrives in the same cycle as the second command accept.
  - Both counts increment; slot 0 is captured correctly.
- Write, req_dat=0xDEAD..., req_sel=16'h00FF:
  - In WRITE_DATA1: wren=end=1 for one cycle, app_wdf_mask=16'hFF00.
  - In WRITE_DATA2: app_en=1 with cmd=0 held until app_rdy; then app_en=0.
- Time-out: state forced to IDLE after 1 of 4 beats:
  - app_en=0 immediately; no line_valid.
  - Next read restarts counts at 0.
- num_strips=9 with MAX_STRIPS=4:
  - Behaves as eff=3: 4 commands, 4 beats, counts saturate at 3.

Source files
------------

// File: rtl/mpmc10_pkg.sv
// mpmc10_pkg: shared controller states, app command codes and strip defaults
package mpmc10_pkg;
    typedef enum logic [3:0] {
        IDLE,
        PRESET1,
        PRESET2,
        PRESET3,
        READ_DATA0,
        READ_DATA1,
        READ_DATA2,
        WRITE_DATA0,
        WRITE_DATA1,
        WRITE_DATA2,
        WRITE_DATA3,
        WAIT_NACK
    } mpmc10_state_t;
    localparam logic [2:0] CMD_READ  = 3'b001;
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam int STRIP_INC_DEF = 16;
endpackage

// File: rtl/mpmc10_strip_buffer.sv
// mpmc10_strip_buffer: MAX_STRIPS x DATA_W line assembly register file
// clk/rst: clock, sync active-high reset; we/idx/din: write din into slot idx; line: all slots, slot 0 in the LSBs
module mpmc10_strip_buffer #(
    parameter int DATA_W     = 128,
    parameter int MAX_STRIPS = 4,
    parameter int IDX_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [IDX_W-1:0]             idx,
    input  logic [DATA_W-1:0]            din,
    output logic [DATA_W*MAX_STRIPS-1:0] line
);
    logic [DATA_W*MAX_STRIPS-1:0] line_q, line_d;
    always_comb begin
        line_d = line_q;
        if (we) line_d[int'(idx)*DATA_W +: DATA_W] = din;
    end
    always_ff @(posedge clk) begin
        if (rst) line_q <= '0;
        else     line_q <= line_d;
    end
    assign line = line_q;
endmodule

// File: rtl/mpmc10_strip_engine.sv
// mpmc10_strip_engine: app command/address/write-data driver and multi-strip read line assembly
// in : clk, rst, state (controller), num_strips (last strip index), req_adr/req_dat/req_sel (sampled in PRESET3),
//      app_rdy, app_rd_data_valid, app_rd_data (MIG)
// out: app_en/app_cmd/app_addr, app_wdf_wren/end/data/mask, req_strip_cnt, resp_strip_cnt, line_dat, line_valid
module mpmc10_strip_engine import mpmc10_pkg::*; #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 29,
    parameter int MAX_STRIPS = 4,
    parameter int STRIP_INC  = STRIP_INC_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  mpmc10_state_t                state,
    input  logic [5:0]                   num_strips,
    input  logic [ADDR_W-1:0]            req_adr,
    input  logic [DATA_W-1:0]            req_dat,
    input  logic [DATA_W/8-1:0]          req_sel,
    input  logic                         app_rdy,
    input  logic                         app_rd_data_valid,
    input  logic [DATA_W-1:0]            app_rd_data,
    output logic                         app_en,
    output logic [2:0]                   app_cmd,
    output logic [ADDR_W-1:0]            app_addr,
    output logic                         app_wdf_wren,
    output logic                         app_wdf_end,
    output logic [DATA_W-1:0]            app_wdf_data,
    output logic [DATA_W/8-1:0]          app_wdf_mask,
    output logic [5:0]                   req_strip_cnt,
    output logic [5:0]                   resp_strip_cnt,
    output logic [DATA_W*MAX_STRIPS-1:0] line_dat,
    output logic                         line_valid
);
    localparam int IDX_W = MAX_STRIPS > 1 ? $clog2(MAX_STRIPS) : 1;
    localparam logic [5:0] MAX_LAST = 6'(MAX_STRIPS - 1);
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic [DATA_W/8-1:0] mask_q, mask_d;
    logic [5:0]          req_cnt_q, req_cnt_d, resp_cnt_q, resp_cnt_d;
    logic                lv_q, lv_d;
    logic [5:0]          eff;
    logic                acc, cap;
    always_comb begin
        eff        = num_strips > MAX_LAST ? MAX_LAST : num_strips;
        // counters stop at eff; "<" keeps them bounded even if num_strips shrinks mid-read
        acc        = state == READ_DATA1 && app_rdy && req_cnt_q < eff;
        cap        = app_rd_data_valid && (state == READ_DATA1 || state == READ_DATA2);
        addr_d     = state == PRESET3 ? req_adr : acc ? addr_q + ADDR_W'(STRIP_INC) : addr_q;
        wdat_d     = state == PRESET3 ? req_dat : wdat_q;
        mask_d     = state == PRESET3 ? ~req_sel : mask_q;
        req_cnt_d  = state == READ_DATA0 ? '0 : acc ? req_cnt_q + 6'd1 : req_cnt_q;
        resp_cnt_d = state == READ_DATA0 ? '0 : (cap && resp_cnt_q < eff) ? resp_cnt_q + 6'd1 : resp_cnt_q;
        lv_d       = cap && resp_cnt_q == eff;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdat_q     <= '0;
            mask_q     <= '0;
            req_cnt_q  <= '0;
            resp_cnt_q <= '0;
            lv_q       <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
            mask_q     <= mask_d;
            req_cnt_q  <= req_cnt_d;
            resp_cnt_q <= resp_cnt_d;
            lv_q       <= lv_d;
        end
    end
    mpmc10_strip_buffer #(
        .DATA_W    (DATA_W),
        .MAX_STRIPS(MAX_STRIPS),
        .IDX_W     (IDX_W)
    ) u_buf (
        .clk (clk),
        .rst (rst),
        .we  (cap),
        .idx (resp_cnt_q[IDX_W-1:0]),
        .din (app_rd_data),
        .line(line_dat)
    );
    assign app_en         = state == READ_DATA1 || state == WRITE_DATA2;
    assign app_cmd        = state == READ_DATA1 ? CMD_READ : CMD_WRITE;
    assign app_addr       = addr_q;
    assign app_wdf_wren   = state == WRITE_DATA1;
    assign app_wdf_end    = state == WRITE_DATA1;
    assign app_wdf_data   = wdat_q;
    assign app_wdf_mask   = mask_q;
    assign req_strip_cnt  = req_cnt_q;
    assign resp_strip_cnt = resp_cnt_q;
    assign line_valid     = lv_q;
endmodule

// File: tb/tb_mpmc10_strip_engine.sv
// tb_mpmc10_strip_engine: decode table, directed read/write/time-out sequences and random reads against a transaction model
module tb_mpmc10_strip_engine;
    import mpmc10_pkg::*;
    localparam int DW = 128, AW = 29, MS = 4, SI = 16, LW = DW * MS;

    logic clk = 1'b0, rst;
    mpmc10_state_t state;
    logic [5:0] num_strips;
    logic [AW-1:0] req_adr;
    logic [DW-1:0] req_dat;
    logic [DW/8-1:0] req_sel;
    logic app_rdy, app_rd_data_valid;
    logic [DW-1:0] app_rd_data;
    logic app_en, app_wdf_wren, app_wdf_end, line_valid;
    logic [2:0] app_cmd;
    logic [AW-1:0] app_addr;
    logic [DW-1:0] app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic [5:0] req_strip_cnt, resp_strip_cnt;
    logic [LW-1:0] line_dat;

    mpmc10_strip_engine #(.DATA_W(DW), .ADDR_W(AW), .MAX_STRIPS(MS), .STRIP_INC(SI)) dut (
        .clk(clk), .rst(rst), .state(state), .num_strips(num_strips),
        .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
        .app_rdy(app_rdy), .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask), .req_strip_cnt(req_strip_cnt), .resp_strip_cnt(resp_strip_cnt),
        .line_dat(line_dat), .line_valid(line_valid)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    typedef struct {
        mpmc10_state_t st;
        logic en;
        logic [2:0] cmd;
        logic wren;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int mn(input int a, input int b);
        return a < b ? a : b;
    endfunction

    // Acts as the controller for one read. The model is transaction level: the address is
    // base + STRIP_INC * (commands accepted, capped at eff), beat i lands in slot i.
    task automatic run_read(input logic [5:0] ns, input logic [AW-1:0] base, input bit use_pat,
                            input logic [31:0] rpat, input logic [31:0] vpat, input int abort_at);
        int eff, acc, k;
        logic [DW-1:0] bq[$];
        logic r, v;
        logic [DW-1:0] d;
        logic [LW-1:0] prev_line;
        logic [AW-1:0] ea;
        eff = mn(int'(ns), MS - 1);
        num_strips = ns;
        state = PRESET3;
        req_adr = base;
        app_rdy = 1'b0;
        app_rd_data_valid = 1'b0;
        tick;
        chk("preset_addr", app_addr, base);
        prev_line = line_dat;
        state = READ_DATA0;
        tick;
        chk("rd0_req", req_strip_cnt, 0);
        chk("rd0_resp", resp_strip_cnt, 0);
        chk("rd0_line", line_dat, prev_line);
        state = READ_DATA1;
        acc = 0;
        k = 0;
        while (bq.size() <= eff) begin
            if (k >= 200) begin
                chk("read_bound", k, 0);
                break;
            end
            r = use_pat ? rpat[k % 32] : ($urandom_range(1) == 1);
            v = (use_pat ? vpat[k % 32] : ($urandom_range(1) == 1)) && (bq.size() < acc);
            d = {$urandom, $urandom, $urandom, $urandom};
            app_rdy = r;
            app_rd_data_valid = v;
            app_rd_data = d;
            #1;
            chk("rd_en", app_en, state == READ_DATA1);
            if (state == READ_DATA1) chk("rd_cmd", app_cmd, CMD_READ);
            tick;
            if (state == READ_DATA1 && r) acc++;
            if (v) bq.push_back(d);
            ea = base + AW'(SI * mn(acc, eff));
            chk("rd_req_cnt", req_strip_cnt, mn(acc, eff));
            chk("rd_addr", app_addr, ea);
            chk("rd_resp_cnt", resp_strip_cnt, mn(bq.size(), eff));
            chk("rd_line_valid", line_valid, v && bq.size() == eff + 1);
            if (state == READ_DATA1 && acc == eff + 1) state = READ_DATA2;
            if (abort_at >= 0 && bq.size() == abort_at) begin
                state = IDLE;
                app_rdy = 1'b1;
                app_rd_data_valid = 1'b1;
                app_rd_data = {$urandom, $urandom, $urandom, $urandom};
                prev_line = line_dat;
                #1;
                chk("to_en", app_en, 0);
                tick;
                chk("to_line_valid", line_valid, 0);
                chk("to_req_hold", req_strip_cnt, mn(acc, eff));
                chk("to_resp_hold", resp_strip_cnt, mn(bq.size(), eff));
                chk("to_line_hold", line_dat, prev_line);
                app_rdy = 1'b0;
                app_rd_data_valid = 1'b0;
                return;
            end
            k++;
        end
        state = IDLE;
        app_rdy = 1'b0;
        app_rd_data_valid = 1'b0;
        #1;
        chk("idle_en", app_en, 0);
        tick;
        chk("idle_line_valid", line_valid, 0);
        for (int i = 0; i <= eff && i < bq.size(); i++) chk($sformatf("slot%0d", i), line_dat[i*DW +: DW], bq[i]);
    endtask

    task automatic run_write(input logic [DW-1:0] dat, input logic [DW/8-1:0] sel, input int delay, input logic [AW-1:0] adr);
        logic [DW/8-1:0] em;
        em = ~sel;
        state = PRESET3;
        req_adr = adr;
        req_dat = dat;
        req_sel = sel;
        app_rdy = 1'b0;
        tick;
        chk("wr_mask", app_wdf_mask, em);
        chk("wr_data", app_wdf_data, dat);
        state = WRITE_DATA0;
        #1;
        chk("wd0_en", app_en, 0);
        chk("wd0_wren", app_wdf_wren, 0);
        tick;
        state = WRITE_DATA1;
        #1;
        chk("wd1_wren", app_wdf_wren, 1);
        chk("wd1_end", app_wdf_end, 1);
        chk("wd1_en", app_en, 0);
        chk("wd1_data", app_wdf_data, dat);
        tick;
        state = WRITE_DATA2;
        for (int i = 0; i <= delay; i++) begin
            app_rdy = (i == delay);
            #1;
            chk("wd2_en", app_en, 1);
            chk("wd2_cmd", app_cmd, CMD_WRITE);
            chk("wd2_wren", app_wdf_wren, 0);
            tick;
            chk("wd2_addr", app_addr, adr);
        end
        state = WRITE_DATA3;
        app_rdy = 1'b0;
        #1;
        chk("wd3_en", app_en, 0);
        chk("wd3_wren", app_wdf_wren, 0);
        tick;
        state = IDLE;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        state = IDLE;
        num_strips = '0;
        req_adr = '0;
        req_dat = '0;
        req_sel = '0;
        app_rdy = 1'b0;
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
        tick;
        tick;
        chk("rst_en", app_en, 0);
        chk("rst_wren", app_wdf_wren, 0);
        chk("rst_end", app_wdf_end, 0);
        chk("rst_addr", app_addr, 0);
        chk("rst_wdata", app_wdf_data, 0);
        chk("rst_mask", app_wdf_mask, 0);
        chk("rst_req", req_strip_cnt, 0);
        chk("rst_resp", resp_strip_cnt, 0);
        chk("rst_line", line_dat, 0);
        chk("rst_lv", line_valid, 0);
        rst = 1'b0;

        tbl[0]  = '{IDLE,        1'b0, CMD_WRITE, 1'b0};
        tbl[1]  = '{PRESET1,     1'b0, CMD_WRITE, 1'b0};
        tbl[2]  = '{PRESET2,     1'b0, CMD_WRITE, 1'b0};
        tbl[3]  = '{PRESET3,     1'b0, CMD_WRITE, 1'b0};
        tbl[4]  = '{READ_DATA0,  1'b0, CMD_WRITE, 1'b0};
        tbl[5]  = '{READ_DATA1,  1'b1, CMD_READ,  1'b0};
        tbl[6]  = '{READ_DATA2,  1'b0, CMD_WRITE, 1'b0};
        tbl[7]  = '{WRITE_DATA0, 1'b0, CMD_WRITE, 1'b0};
        tbl[8]  = '{WRITE_DATA1, 1'b0, CMD_WRITE, 1'b1};
        tbl[9]  = '{WRITE_DATA2, 1'b1, CMD_WRITE, 1'b0};
        tbl[10] = '{WRITE_DATA3, 1'b0, CMD_WRITE, 1'b0};
        tbl[11] = '{WAIT_NACK,   1'b0, CMD_WRITE, 1'b0};
        for (int i = 0; i < 12; i++) begin
            state = tbl[i].st;
            #2;
            chk($sformatf("tbl%0d_en", i), app_en, tbl[i].en);
            if (tbl[i].en) chk($sformatf("tbl%0d_cmd", i), app_cmd, tbl[i].cmd);
            chk($sformatf("tbl%0d_wren", i), app_wdf_wren, tbl[i].wren);
            chk($sformatf("tbl%0d_end", i), app_wdf_end, tbl[i].wren);
        end
        state = IDLE;
        tick;

        run_read(6'd3, 29'h100, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, -1);
        run_read(6'd1, 29'h200, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFF0, -1);
        run_read(6'd1, 29'h300, 1'b1, 32'h0000_0003, 32'hFFFF_FFFE, -1);
        run_write({4{32'hDEAD_BEEF}}, 16'h00FF, 3, 29'h1234);
        run_read(6'd3, 29'h400, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
        run_read(6'd3, 29'h480, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, -1);
        run_read(6'd9, 29'h500, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, -1);

        state = PRESET3;
        req_adr = 29'h55;
        tick;
        state = READ_DATA0;
        tick;
        state = READ_DATA1;
        app_rdy = 1'b1;
        tick;
        tick;
        rst = 1'b1;
        state = IDLE;
        app_rdy = 1'b0;
        tick;
        chk("mrst_addr", app_addr, 0);
        chk("mrst_req", req_strip_cnt, 0);
        chk("mrst_mask", app_wdf_mask, 0);
        chk("mrst_line", line_dat, 0);
        chk("mrst_lv", line_valid, 0);
        rst = 1'b0;
        tick;

        for (int t = 0; t < 25; t++) begin
            logic [5:0] ns;
            int ab;
            ns = 6'($urandom_range(9));
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(mn(int'(ns), MS - 1))) : -1;
            run_read(ns, AW'($urandom), 1'b0, 32'h0, 32'h0, ab);
            if ($urandom_range(2) == 0)
                run_write({$urandom, $urandom, $urandom, $urandom}, 16'($urandom), int'($urandom_range(3)), AW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
